// File: rtl/shift_if.sv
// Operand/result bundle for the shift block: control and load operand flow
// from the master to the shifter, the registered result flows back.
interface shift_if #(
   parameter int WIDTH = 8
) ();
   logic             dir;
   logic             en;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] y;

   modport master (output dir, output en, output a, input  y);
   modport slave  (input  dir, input  en, input  a, output y);
endinterface

// File: rtl/shift.sv
// Parameterised logical shift register with parallel load and direction select.
// Load beats shift; vacated bits are zero-filled, so WIDTH shifts drain it to 0.
module shift #(
   parameter int WIDTH = 8
) (
   input  logic             dir,
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y,
   input  logic             rst_n
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] shl;
   logic [WIDTH-1:0] shr;

   assign shl = {q_q[WIDTH-2:0], 1'b0};
   assign shr = {1'b0, q_q[WIDTH-1:1]};

   always_comb begin
      q_d = q_q;
      if (en) begin
         q_d = a;
      end else if (dir) begin
         q_d = shr;
      end else begin
         q_d = shl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   // Output straight from the register: no input-to-y combinational path.
   assign y = q_q;

endmodule

// File: tb/tb_shift.sv
// Self-checking bench for shift: directed scenarios plus randomized traffic,
// checked against an arithmetic model of the register contents.
module tb_shift;
   localparam int W = 8;
   localparam int MOD = 1 << W;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   int   model;

   shift_if #(.WIDTH(W)) bus ();

   shift #(.WIDTH(W)) dut (
      .dir   (bus.dir),
      .clk   (clk),
      .en    (bus.en),
      .a     (bus.a),
      .y     (bus.y),
      .rst_n (rst_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: y=%h expected=%h", tag, obs, exp);
      end
      $display("t=%0t %s y=%h exp=%h", $time, tag, obs, exp);
   endtask

   // Reference: the register as an integer; shifts are multiply/divide by two.
   function automatic int next_val(input int cur, input logic e, input logic d, input int av);
      if (e) return av;
      if (d) return cur / 2;
      return (cur * 2) % MOD;
   endfunction

   task automatic step(input string tag, input logic e, input logic d, input logic [W-1:0] av);
      bus.en  = e;
      bus.dir = d;
      bus.a   = av;
      @(posedge clk);
      if (!rst_n) model = 0;
      else        model = next_val(model, e, d, int'(av));
      #1;
      check(tag, bus.y, model[W-1:0]);
   endtask

   task automatic pulse_reset(input string tag);
      rst_n = 1'b0;
      model = 0;
      #1;
      check(tag, bus.y, '0);
      #1;
      rst_n = 1'b1;
   endtask

   logic [W-1:0] left_tab  [5];
   logic [W-1:0] right_tab [5];
   logic [W-1:0] reload_tab[3];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      model = 0;
      left_tab   = '{8'hAA, 8'h54, 8'hA8, 8'h50, 8'hA0};
      right_tab  = '{8'hCD, 8'h66, 8'h33, 8'h19, 8'h0C};
      reload_tab = '{8'h3C, 8'hC3, 8'h5A};
      bus.en  = 1'b0;
      bus.dir = 1'b0;
      bus.a   = '0;
      rst_n   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_initial", bus.y, '0);
      rst_n = 1'b1;

      // Reset clears a held FF immediately, then holds 0 across loading edges.
      step("load_ff", 1'b1, 1'b0, 8'hFF);
      rst_n = 1'b0;
      model = 0;
      #1;
      check("async_reset", bus.y, '0);
      for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 1'b0, 8'hAA);
      rst_n = 1'b1;

      step("left_load", 1'b1, 1'b0, 8'hAA);
      check("left_tab0", bus.y, left_tab[0]);
      for (int i = 1; i < 5; i++) begin
         step("left_shift", 1'b0, 1'b0, 8'h00);
         check("left_tab", bus.y, left_tab[i]);
      end

      step("right_load", 1'b1, 1'b1, 8'hCD);
      check("right_tab0", bus.y, right_tab[0]);
      for (int i = 1; i < 5; i++) begin
         step("right_shift", 1'b0, 1'b1, 8'hFF);
         check("right_tab", bus.y, right_tab[i]);
      end

      step("drain_load", 1'b1, 1'b0, 8'hFF);
      for (int i = 1; i <= 10; i++) step("drain_shift", 1'b0, 1'b0, 8'h00);
      check("drain_zero", bus.y, '0);

      for (int i = 0; i < 3; i++) begin
         step("reload", 1'b1, i[0], reload_tab[i]);
         check("reload_tab", bus.y, reload_tab[i]);
      end

      step("mid_load", 1'b1, 1'b0, 8'h81);
      step("mid_shift", 1'b0, 1'b1, 8'h00);
      check("mid_shift_40", bus.y, 8'h40);
      pulse_reset("mid_reset");
      step("post_reset_r", 1'b0, 1'b1, 8'hFF);
      step("post_reset_l", 1'b0, 1'b0, 8'hFF);
      check("post_reset_zero", bus.y, '0);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 49) == 0) pulse_reset("rand_reset");
         step("rand", ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              W'($urandom_range(0, MOD - 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
